// File: rtl/vme_rd_pkg.sv
// vme_rd_pkg: shared states, lane indices, defaults and fill value for the VME byte-read sequencer
package vme_rd_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SETTLE, ACK, ABORT, ERR} state_e;
  localparam logic [1:0] LANE_D0 = 2'd0;
  localparam logic [1:0] LANE_D1 = 2'd1;
  localparam logic [1:0] LANE_D2 = 2'd2;
  localparam logic [1:0] LANE_D3 = 2'd3;
  localparam int TIMEOUT_DEF = 15;
  localparam int DTACK_DLY_DEF = 1;
  localparam logic [7:0] FILL = 8'hFF;
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    return w[8*l +: 8];
  endfunction
endpackage

// File: rtl/vme_rd_tmo.sv
// vme_rd_tmo: loadable down-counter; expired flags the last counted cycle while enabled
module vme_rd_tmo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = en && cnt_q == W'(1);
endmodule

// File: rtl/vme_rd_byte_seq.sv
// vme_rd_byte_seq: D08 read sequencer with one-word cache, lane hold and DTACK/BERR handshake.
// Define VME_RD_BERR_EN to signal fetch timeouts with berr instead of an 8'hFF filled dtack.
module vme_rd_byte_seq
  import vme_rd_pkg::*;
#(
  parameter int AW        = 8,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int DTACK_DLY = DTACK_DLY_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_req,
  input  logic [AW+1:0] rd_addr,
  input  logic          ds_active,
  input  logic          inval,
  output logic          reg_rd,
  output logic [AW-1:0] reg_addr,
  input  logic [31:0]   reg_data,
  input  logic          reg_ack,
  output logic [7:0]    byte_d0,
  output logic [7:0]    byte_d1,
  output logic [7:0]    byte_d2,
  output logic [7:0]    byte_d3,
  output logic [1:0]    sel,
  output logic          drv_en,
  output logic          dtack,
  output logic          berr
);
`ifdef VME_RD_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [AW-1:0] tag_q, tag_d, addr_q, addr_d;
  logic [1:0] sel_q, sel_d;
  logic valid_q, valid_d, inv_q, inv_d;
  logic reg_rd_q, reg_rd_d, drv_en_q, drv_en_d, dtack_q, dtack_d, berr_q, berr_d;
  logic tmo_load, tmo_exp, dly_load, dly_exp, hit;
  assign hit = valid_q && tag_q == rd_addr[AW+1:2] && !inval;
  vme_rd_tmo #(.W(8)) u_tmo (
    .clk(clk), .rst(reset), .load(tmo_load), .en(state_q == FETCH),
    .load_val(8'(TIMEOUT)), .expired(tmo_exp)
  );
  vme_rd_tmo #(.W(3)) u_dly (
    .clk(clk), .rst(reset), .load(dly_load), .en(state_q == SETTLE),
    .load_val(3'(DTACK_DLY)), .expired(dly_exp)
  );
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    tag_d = tag_q;
    addr_d = addr_q;
    sel_d = sel_q;
    valid_d = valid_q && !inval;
    inv_d = inv_q || inval;
    tmo_load = 1'b0;
    dly_load = 1'b0;
    case (state_q)
      IDLE: if (rd_req) begin
        sel_d = rd_addr[1:0];
        state_d = hit ? SETTLE : FETCH;
        dly_load = hit;
        tmo_load = !hit;
        if (!hit) begin
          addr_d = rd_addr[AW+1:2];
          valid_d = 1'b0;
          inv_d = 1'b0;
        end
      end
      FETCH: if (reg_ack) begin
        // an invalidate seen at any point of the fetch keeps the fresh word uncached
        word_d = reg_data;
        tag_d = addr_q;
        valid_d = !(inval || inv_q);
        state_d = ds_active ? SETTLE : IDLE;
        dly_load = ds_active;
      end else if (tmo_exp) begin
        word_d = BERR_EN ? word_q : {4{FILL}};
        valid_d = 1'b0;
        state_d = ERR;
      end
      ERR: begin
        state_d = !ds_active ? IDLE : BERR_EN ? ERR : SETTLE;
        dly_load = !BERR_EN && ds_active;
      end
      SETTLE: state_d = !ds_active ? IDLE : dly_exp ? ACK : SETTLE;
      ACK: state_d = ds_active ? ACK : IDLE;
      default: state_d = IDLE;
    endcase
    reg_rd_d = state_d == FETCH;
    drv_en_d = state_d == SETTLE || state_d == ACK;
    dtack_d = state_d == ACK;
    berr_d = BERR_EN && state_d == ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q <= '0;
      tag_q <= '0;
      addr_q <= '0;
      sel_q <= '0;
      valid_q <= 1'b0;
      inv_q <= 1'b0;
      reg_rd_q <= 1'b0;
      drv_en_q <= 1'b0;
      dtack_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      tag_q <= tag_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      valid_q <= valid_d;
      inv_q <= inv_d;
      reg_rd_q <= reg_rd_d;
      drv_en_q <= drv_en_d;
      dtack_q <= dtack_d;
      berr_q <= berr_d;
    end
  end
  assign reg_rd = reg_rd_q;
  assign reg_addr = addr_q;
  assign sel = sel_q;
  assign drv_en = drv_en_q;
  assign dtack = dtack_q;
  assign berr = berr_q;
  assign byte_d0 = lane_byte(word_q, LANE_D0);
  assign byte_d1 = lane_byte(word_q, LANE_D1);
  assign byte_d2 = lane_byte(word_q, LANE_D2);
  assign byte_d3 = lane_byte(word_q, LANE_D3);
endmodule

// File: doc/vme_rd_byte_seq.md
# vme_rd_byte_seq

Byte-read sequencer for the VME64 slave read path: on each D08 read cycle it fetches the addressed 32-bit register word from the local register file, or reuses the cached word on a hit. It holds the word on four byte lanes and drives the 2-bit lane select into the downstream 4:1 byte read multiplexer. It then runs the DTACK/BERR handshake toward the bus-side control logic until the data strobe is released.

## Interface
- AW, 8, register word-address width
- TIMEOUT, 15, cycles allowed between fetch start and reg_ack (1..255)
- DTACK_DLY, 1, cycles lanes/sel are stable before dtack asserts (1..7)

- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- rd_req  in  1  one-cycle pulse: new byte read cycle decoded (strobes already synchronized)
- rd_addr  in  AW+2  [AW+1:2] word address, [1:0] byte offset (offset 0 = MSB, big-endian)
- ds_active  in  1  synchronized data-strobe level; low ends the bus cycle
- inval  in  1  one-cycle pulse: cached word is stale (write decoded)
- reg_rd  out  1  register-file read request, level
- reg_addr  out  AW  word address for reg_rd
- reg_data  in  32  register-file read data, valid with reg_ack
- reg_ack  in  1  one-cycle read acknowledge
- byte_d0..byte_d3  out  8 each  lanes to mux din0..din3: d0=word[7:0], d1=[15:8], d2=[23:16], d3=[31:24]
- sel  out  2  mux select = byte offset (11→d0 … 00→d3)
- drv_en  out  1  data-bus output enable
- dtack  out  1  data acknowledge to bus control
- berr  out  1  bus error (only when VME_RD_BERR_EN defined; else tied 0)

## Operation
- States: IDLE, FETCH, SETTLE, ACK, ABORT, ERR.
- IDLE: on rd_req, latch sel←rd_addr[1:0], compare rd_addr[AW+1:2] with cached tag. Hit (valid && tag match && !inval) → SETTLE. Otherwise → FETCH.
- FETCH: reg_rd=1, reg_addr=tag. On reg_ack: capture reg_data into lanes, tag←address, valid←1. Go to SETTLE if ds_active is high; go to ABORT-exit (IDLE) if ds_active dropped meanwhile.
- SETTLE: drv_en=1 and a DTACK_DLY counter runs. On expiry → ACK.
- ACK: dtack=1 until ds_active=0. Then → IDLE; dtack and drv_en deassert together.
- Timeout: a counter starts on FETCH entry. If TIMEOUT cycles pass without reg_ack, go to ERR and leave valid=0.
- rd_req outside IDLE: ignored.
- inval: clears valid in every state. If inval coincides with rd_req, inval wins and the access is a miss. If inval occurs during FETCH, the word is used for the current cycle but valid stays 0.
- ds_active low at entry to SETTLE or ACK: go to IDLE without asserting dtack.

## Timing
- Reset values: reg_rd=0, reg_addr=0, lanes=8'h00, sel=2'b00, drv_en=0, dtack=0, berr=0, valid=0, state=IDLE.
- All outputs registered.
- Hit: rd_req at cycle 0. drv_en rises at cycle 1, dtack rises at cycle 1+DTACK_DLY.
- Miss: reg_rd rises at cycle 1 and is held through the cycle where reg_ack is sampled, then falls. Lanes update on that edge, drv_en rises on the next cycle, and dtack follows DTACK_DLY cycles later.
- Release: ds_active sampled 0 in ACK → dtack=0 and drv_en=0 next cycle.
- reg_ack arriving outside FETCH is ignored.

## Configuration
- VME_RD_BERR_EN defined: ERR drives berr=1 and drv_en=0 until ds_active=0, then → IDLE.
- VME_RD_BERR_EN not defined: ERR loads all lanes with 8'hFF, then follows SETTLE/ACK (normal dtack). berr is constant 0.

## Structure
- Shared package/include vme_rd_pkg:
  - state encodings
  - lane index constants
  - TIMEOUT/DTACK_DLY defaults
  - 8'hFF fill constant
- One sub-module, vme_rd_tmo: loadable down-counter with expiry flag, instantiated twice (fetch timeout, DTACK_DLY settle).

## Test plan
- Reset, then miss at address 0x010 offset 2, reg_data=0x11223344, ack after 3 cycles → sel=10, byte_d1=0x33, dtack at ack+1+DTACK_DLY.
- Second read of same word, offset 0 → no reg_rd, sel=00, dtack at cycle 2 (DTACK_DLY=1).
- inval pulse then same-word read → reg_rd reasserted. inval coincident with rd_req → miss.
- No reg_ack for 15 cycles:
  - with VME_RD_BERR_EN → berr=1 until ds_active=0, dtack stays 0;
  - without it → lanes=0xFF, dtack=1.
- ds_active dropped during FETCH → word captured, no dtack, IDLE. rd_req during ACK ignored.
- reset asserted in SETTLE → all outputs at reset values next cycle; the next read is a miss.
